bootdata_loader: RTL and testbench
==================================

// Module: bootdata_loader
// PURPOSE
//  Parametrised host-to-memory boot loader: accepts HOST_W-bit words from the control module over a
//  four-phase req/ack handshake, unpacks them MSB-byte-first and writes them to one of NUM_TGT target
//  memories (cart SRAM, char RAM, ...). Holds the console core in reset until an exact byte count lands.
// PARAMETERS
//  HOST_W   32  host word width; multiple of 8, 8..64; BPW = HOST_W/8 bytes per word
//  ADDR_W   19  byte address width toward targets
//  SIZE_W   16  width of byte-count/size fields
//  NUM_TGT  2   number of target memories (one-hot write enables)
// PORTS
//  clk            in   1            system clock
//  reset          in   1            sync active-high; full reset, core held in reset
//  boot_reset     in   1            sync active-high soft restart of a load session (host_bootdata_reset)
//  host_data      in   HOST_W       boot word, valid while host_req=1
//  host_req       in   1            host request (level)
//  host_ack       out  1            loader acknowledge (level, four-phase)
//  host_size      in   SIZE_W       total bytes of this session; latched with first word
//  tgt_sel        in   clog2(NUM_TGT) target index; latched with first word
//  mem_addr       out  ADDR_W       byte address for all targets
//  mem_data       out  8            write byte
//  mem_we         out  NUM_TGT      one-hot write strobe, 1 cycle per byte
//  bytes_loaded   out  SIZE_W       bytes written this session
//  load_done      out  1            exact size reached (sticky until reset/boot_reset)
//  load_ovf       out  1            word offered after done (sticky)
//  core_rst_n     out  1            0 while reset=1 or load_done=0
// BEHAVIOUR
//  - Clock: single clk. Reset: reset/boot_reset are synchronous, active-high; either -> state IDLE,
//    host_ack=0, mem_we=0, mem_addr=0, mem_data=0, bytes_loaded=0, load_done=0, load_ovf=0, core_rst_n=0.
//    Asserting either mid-word aborts the current word immediately (no further strobes).
//  - States: IDLE, WRITE, GAP, WAITREL.
//    IDLE: host_req=1 && host_ack=0 at cycle n -> latch word; if first word also latch host_size, tgt_sel;
//      n+1: host_ack=1, state WRITE.
//    WRITE: if !load_done: mem_we[tgt]=1, mem_data=current byte, mem_addr=bytes_loaded; next cycle
//      bytes_loaded+1. -> GAP.
//    GAP: mem_we=0 (SRAM recovery cycle). More bytes in word and count<size -> WRITE; else -> WAITREL.
//    WAITREL: host_ack held 1 until host_req sampled 0, then ack->0, -> IDLE.
//  - Timing: word accepted at n -> byte k strobed at n+1+2k, k=0..BPW-1; ack high from n+1.
//  - Byte order: byte0 = host_data[HOST_W-1 -: 8], descending.
//  - Exact size: writing stops when bytes_loaded==host_size even mid-word (partial last word); remaining
//    bytes dropped. load_done=1 the cycle after final strobe; core_rst_n rises same cycle (if reset=0).
//  - host_size=0: load_done=1 the cycle after the first word is acked; no strobes.
//  - After done: words still handshaken, never written; load_ovf=1 the cycle after ack.
//  - bytes_loaded saturates at 2^SIZE_W-1; mem_addr = zero-extended / truncated bytes_loaded.
//  - host_req dropping before ack: word already latched, completes normally.
// CONFIGURATION
//  BOOT_CHECKSUM_EN defined: adds ports chk_expect in 8 (latched with first word), chk_sum out 8 (8-bit
//   modulo-256 sum of written bytes, 0 at reset), chk_ok out 1 (=load_done && chk_sum==chk_expect);
//   core_rst_n additionally requires chk_ok. Undefined: ports absent, core_rst_n as above.
// STRUCTURE
//  Shared package bootdata_pkg: state enum, BPW calc, target index constants (TGT_SRAM=0, TGT_CHAR=1).
//  Sub-module bootdata_unpack: HOST_W shift register + byte counter emitting one byte per request.
// TESTING
//  1 HOST_W=32, size=8, words 0x11223344,0x55667788 -> strobes addr0..7 data 11..88 at n+1,3,5,7; done after 8th.
//  2 size=6 -> second word writes 0x55,0x66 only; bytes_loaded=6, done=1, no strobe at addr 6.
//  3 After done, extra word 0xDEADBEEF -> acked, mem_we stays 0, load_ovf=1, core_rst_n=1.
//  4 boot_reset after byte1 of word -> next cycle mem_we=0, bytes_loaded=0, done=0, ack=0.
//  5 tgt_sel=1, size=4 -> only mem_we[1] pulses; mem_we[0] never 1; host holds req 3 extra cycles -> ack holds.
//  6 BOOT_CHECKSUM_EN, bytes 01,02,03,04, chk_expect=0x0A -> chk_ok=1; chk_expect=0x0B -> core_rst_n=0.

Source files
------------

// File: rtl/bootdata_pkg.sv
// bootdata_pkg
//  Shared definitions for the boot data loader: loader state encoding,
//  bytes-per-word and select-width helpers, and the target index constants
//  used to address the one-hot target write strobes.
package bootdata_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    GAP     = 2'd2,
    WAITREL = 2'd3
  } state_t;

  localparam int TGT_SRAM = 0;
  localparam int TGT_CHAR = 1;

  function automatic int bytes_per_word(input int host_w);
    return host_w / 8;
  endfunction

  // A single target still needs a 1-bit select field.
  function automatic int sel_width(input int num_tgt);
    return (num_tgt > 1) ? $clog2(num_tgt) : 1;
  endfunction

endpackage

// File: rtl/bootdata_if.sv
// bootdata_if
//  Host-side four-phase handshake bundle for the boot loader.
//  Signals:
//    host_data  boot word, valid while host_req=1
//    host_req   host request level
//    host_ack   loader acknowledge level
//    host_size  total session byte count (taken with the first word)
//    tgt_sel    target memory index (taken with the first word)
//  Modports: master = control module (host), slave = loader.
interface bootdata_if
#(
  parameter int HOST_W = 32,
  parameter int SIZE_W = 16,
  parameter int SEL_W  = 1
);
  import bootdata_pkg::*;

  logic [HOST_W-1:0] host_data;
  logic              host_req;
  logic              host_ack;
  logic [SIZE_W-1:0] host_size;
  logic [SEL_W-1:0]  tgt_sel;

  modport master (
    output host_data, host_req, host_size, tgt_sel,
    input  host_ack
  );

  modport slave (
    input  host_data, host_req, host_size, tgt_sel,
    output host_ack
  );

endinterface

// File: rtl/bootdata_unpack.sv
// bootdata_unpack
//  Holds one host word and hands it out MSB byte first.
//  Ports:
//    clk       system clock
//    clear     synchronous clear (full reset or session restart)
//    load      capture word, byte index back to 0
//    advance   shift to the next byte, index +1
//    word      host word to capture
//    cur_byte  byte currently at the top of the shift register
//    more      cur_byte is still an unconsumed byte of the word
module bootdata_unpack
  import bootdata_pkg::*;
#(
  parameter int HOST_W = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic              advance,
  input  logic [HOST_W-1:0] word,
  output logic [7:0]        cur_byte,
  output logic              more
);

  localparam int BPW = bytes_per_word(HOST_W);
  localparam int CW  = $clog2(BPW + 1);

  logic [HOST_W-1:0] shreg;
  logic [CW-1:0]     used;

  always_ff @(posedge clk) begin
    if (clear) begin
      shreg <= '0;
      used  <= '0;
    end else if (load) begin
      shreg <= word;
      used  <= '0;
    end else if (advance) begin
      shreg <= shreg << 8;
      used  <= used + CW'(1);
    end
  end

  assign cur_byte = shreg[HOST_W-1 -: 8];
  assign more     = (used < CW'(BPW));

endmodule

// File: rtl/bootdata_loader.sv
// bootdata_loader
//  Accepts host words over a four-phase req/ack handshake, unpacks them
//  MSB byte first and writes each byte (one strobe every other cycle) into
//  the selected target memory. Keeps the console core in reset until the
//  exact session byte count has been written.
//  Ports:
//    clk, reset        system clock, synchronous active-high full reset
//    boot_reset        synchronous active-high restart of a load session
//    host              bootdata_if.slave handshake bundle
//    mem_addr/mem_data byte address / data shared by all targets
//    mem_we            one-hot per-target write strobe
//    bytes_loaded      bytes written this session (saturating)
//    load_done         session size reached (sticky)
//    load_ovf          word offered after done (sticky)
//    core_rst_n        console core reset, low until the load is complete
//  Optional feature macro BOOT_CHECKSUM_EN adds chk_expect (in), chk_sum and
//  chk_ok (out); the core is then also held in reset until the checksum matches.
module bootdata_loader
  import bootdata_pkg::*;
#(
  parameter int HOST_W  = 32,
  parameter int ADDR_W  = 19,
  parameter int SIZE_W  = 16,
  parameter int NUM_TGT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               boot_reset,
  bootdata_if.slave          host,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [7:0]         mem_data,
  output logic [NUM_TGT-1:0] mem_we,
  output logic [SIZE_W-1:0]  bytes_loaded,
  output logic               load_done,
  output logic               load_ovf,
  output logic               core_rst_n
`ifdef BOOT_CHECKSUM_EN
  ,
  input  logic [7:0]         chk_expect,
  output logic [7:0]         chk_sum,
  output logic               chk_ok
`endif
);

  localparam int SEL_W = sel_width(NUM_TGT);

  state_t            state;
  logic              first_word;
  logic [SIZE_W-1:0] size_q;
  logic [SIZE_W-1:0] size_now;
  logic [SIZE_W-1:0] count_next;
  logic [SEL_W-1:0]  tgt_q;
  logic [SEL_W-1:0]  tgt_now;
  logic              clear;
  logic              accept;
  logic              byte_more;
  logic [7:0]        byte_cur;

  assign clear  = reset | boot_reset;
  assign accept = (state == IDLE) && host.host_req && !host.host_ack;

  // Size and target are taken from the bus on the first word of a session
  // so the very first strobe already uses them.
  assign size_now   = first_word ? host.host_size : size_q;
  assign tgt_now    = first_word ? host.tgt_sel   : tgt_q;
  assign count_next = (bytes_loaded == '1) ? bytes_loaded : bytes_loaded + SIZE_W'(1);

  bootdata_unpack #(.HOST_W(HOST_W)) u_unpack (
    .clk      (clk),
    .clear    (clear),
    .load     (accept),
    .advance  (state == WRITE),
    .word     (host.host_data),
    .cur_byte (byte_cur),
    .more     (byte_more)
  );

  // Strobes are registered on the transition into WRITE, so WRITE cycles
  // carry the strobe and GAP cycles are the idle recovery cycle between bytes.
  always_ff @(posedge clk) begin
    if (clear) begin
      state         <= IDLE;
      host.host_ack <= 1'b0;
      mem_we        <= '0;
      mem_addr      <= '0;
      mem_data      <= '0;
      bytes_loaded  <= '0;
      load_done     <= 1'b0;
      load_ovf      <= 1'b0;
      first_word    <= 1'b1;
      size_q        <= '0;
      tgt_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            host.host_ack <= 1'b1;
            state         <= WRITE;
            if (first_word) begin
              size_q     <= host.host_size;
              tgt_q      <= host.tgt_sel;
              first_word <= 1'b0;
            end
            if (!load_done && (bytes_loaded < size_now)) begin
              mem_we   <= NUM_TGT'(1) << tgt_now;
              mem_data <= host.host_data[HOST_W-1 -: 8];
              mem_addr <= ADDR_W'(bytes_loaded);
            end
          end
        end
        WRITE: begin
          mem_we <= '0;
          state  <= GAP;
          if (mem_we != '0) begin
            bytes_loaded <= count_next;
            if (count_next >= size_q) begin
              load_done <= 1'b1;
            end
          end else if (load_done) begin
            load_ovf <= 1'b1;
          end else begin
            // No strobe without done only happens for a zero-byte session.
            load_done <= 1'b1;
          end
        end
        GAP: begin
          if (byte_more && !load_done && (bytes_loaded < size_q)) begin
            mem_we   <= NUM_TGT'(1) << tgt_q;
            mem_data <= byte_cur;
            mem_addr <= ADDR_W'(bytes_loaded);
            state    <= WRITE;
          end else begin
            state <= WAITREL;
          end
        end
        WAITREL: begin
          if (!host.host_req) begin
            host.host_ack <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] chk_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      chk_sum <= '0;
      chk_q   <= '0;
    end else begin
      if (accept && first_word) begin
        chk_q <= chk_expect;
      end
      if ((state == WRITE) && (mem_we != '0)) begin
        chk_sum <= chk_sum + mem_data;
      end
    end
  end

  assign chk_ok     = load_done && (chk_sum == chk_q);
  assign core_rst_n = !reset && load_done && chk_ok;
`else
  assign core_rst_n = !reset && load_done;
`endif

endmodule

// File: tb/tb_bootdata_loader.sv
// tb_bootdata_loader
//  Directed bench for bootdata_loader (HOST_W=32, two targets). A negedge
//  monitor logs every write strobe with its cycle number; directed steps
//  then compare the log and status outputs against hand-computed values.
//  Builds with or without BOOT_CHECKSUM_EN.
module tb_bootdata_loader;
  import bootdata_pkg::*;

  localparam int HOST_W  = 32;
  localparam int ADDR_W  = 19;
  localparam int SIZE_W  = 16;
  localparam int NUM_TGT = 2;
  localparam int SEL_W   = 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               boot_reset;
  logic [ADDR_W-1:0]  mem_addr;
  logic [7:0]         mem_data;
  logic [NUM_TGT-1:0] mem_we;
  logic [SIZE_W-1:0]  bytes_loaded;
  logic               load_done;
  logic               load_ovf;
  logic               core_rst_n;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]         chk_expect;
  logic [7:0]         chk_sum;
  logic               chk_ok;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int q_cyc[$];
  int q_we[$];
  int q_addr[$];
  int q_data[$];
  bit done_seen;
  bit ovf_seen;
  int done_cycle;
  int ovf_cycle;
  int sram_pulses;

  bootdata_if #(.HOST_W(HOST_W), .SIZE_W(SIZE_W), .SEL_W(SEL_W)) host_bus ();

  bootdata_loader #(
    .HOST_W(HOST_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .NUM_TGT(NUM_TGT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .boot_reset   (boot_reset),
    .host         (host_bus),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_we       (mem_we),
    .bytes_loaded (bytes_loaded),
    .load_done    (load_done),
    .load_ovf     (load_ovf),
    .core_rst_n   (core_rst_n)
`ifdef BOOT_CHECKSUM_EN
    ,
    .chk_expect   (chk_expect),
    .chk_sum      (chk_sum),
    .chk_ok       (chk_ok)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we != '0) begin
      q_cyc.push_back(cyc);
      q_we.push_back(int'(mem_we));
      q_addr.push_back(int'(mem_addr));
      q_data.push_back(int'(mem_data));
    end
    if (mem_we[TGT_SRAM]) sram_pulses++;
    if (load_done && !done_seen) begin
      done_seen  = 1'b1;
      done_cycle = cyc;
    end
    if (load_ovf && !ovf_seen) begin
      ovf_seen  = 1'b1;
      ovf_cycle = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    q_cyc.delete();
    q_we.delete();
    q_addr.delete();
    q_data.delete();
    done_seen   = 1'b0;
    ovf_seen    = 1'b0;
    done_cycle  = -1;
    ovf_cycle   = -1;
    sram_pulses = 0;
  endtask

  // Restart a session; size/target/checksum are taken with its first word.
  task automatic start_session(input int size, input int sel, input logic [7:0] chk);
    host_bus.host_size = SIZE_W'(size);
    host_bus.tgt_sel   = SEL_W'(sel);
`ifdef BOOT_CHECKSUM_EN
    chk_expect = chk;
`else
    if (chk != 8'h00) $display("[TB] checksum value %0h unused in this build", chk);
`endif
    boot_reset = 1'b1;
    tick();
    boot_reset = 1'b0;
    clear_log();
  endtask

  // One four-phase transfer; acc is the first cycle with ack high.
  task automatic apply_stimulus(input logic [31:0] word, input int hold, output int acc);
    host_bus.host_data = word;
    host_bus.host_req  = 1'b1;
    acc = -1;
    for (int i = 0; i < 5 && acc < 0; i++) begin
      tick();
      if (host_bus.host_ack) acc = cyc;
    end
    check_output("ack_rise", 64'(host_bus.host_ack), 64'(1'b1));
    for (int i = 0; i < hold; i++) tick();
    check_output("ack_hold", 64'(host_bus.host_ack), 64'(1'b1));
    host_bus.host_req = 1'b0;
    for (int i = 0; i < 20 && host_bus.host_ack; i++) tick();
    check_output("ack_fall", 64'(host_bus.host_ack), 64'(1'b0));
  endtask

  task automatic check_log(input string tag, input int k, input int we, input int addr,
                           input int data, input int cyc_exp);
    if (k < q_we.size()) begin
      check_output({tag, "_we"},   64'(q_we[k]),   64'(we));
      check_output({tag, "_addr"}, 64'(q_addr[k]), 64'(addr));
      check_output({tag, "_data"}, 64'(q_data[k]), 64'(data));
      check_output({tag, "_cyc"},  64'(q_cyc[k]),  64'(cyc_exp));
    end else begin
      check_output({tag, "_present"}, 64'(q_we.size()), 64'(k + 1));
    end
  endtask

  initial begin
    int a1, a2, a3, a5, a6;
    logic [7:0] bytes_t1 [8];
    logic [7:0] bytes_t5 [4];

    bytes_t1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    bytes_t5 = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};

    reset              = 1'b1;
    boot_reset         = 1'b0;
    host_bus.host_data = '0;
    host_bus.host_req  = 1'b0;
    host_bus.host_size = '0;
    host_bus.tgt_sel   = '0;
`ifdef BOOT_CHECKSUM_EN
    chk_expect = 8'h00;
`endif
    clear_log();
    tick();
    tick();

    $display("[TB] reset state");
    check_output("rst_ack",   64'(host_bus.host_ack), 64'(1'b0));
    check_output("rst_we",    64'(mem_we),            64'(2'b00));
    check_output("rst_addr",  64'(mem_addr),          64'(19'd0));
    check_output("rst_data",  64'(mem_data),          64'(8'h00));
    check_output("rst_bytes", 64'(bytes_loaded),      64'(16'd0));
    check_output("rst_done",  64'(load_done),         64'(1'b0));
    check_output("rst_ovf",   64'(load_ovf),          64'(1'b0));
    check_output("rst_core",  64'(core_rst_n),        64'(1'b0));
    reset = 1'b0;
    tick();

    $display("[TB] two full words, size 8");
    start_session(8, TGT_SRAM, 8'h64);
    apply_stimulus(32'h11223344, 9, a1);
    check_output("t1_mid_bytes", 64'(bytes_loaded), 64'(16'd4));
    check_output("t1_mid_done",  64'(load_done),    64'(1'b0));
    check_output("t1_mid_core",  64'(core_rst_n),   64'(1'b0));
    apply_stimulus(32'h55667788, 9, a2);
    check_output("t1_count", 64'(q_we.size()), 64'(8));
    for (int k = 0; k < 8; k++) begin
      check_log($sformatf("t1_b%0d", k), k, 1, k, int'(bytes_t1[k]),
                ((k < 4) ? a1 : a2) + 2 * (k % 4));
    end
    check_output("t1_bytes",    64'(bytes_loaded), 64'(16'd8));
    check_output("t1_done",     64'(load_done),    64'(1'b1));
    check_output("t1_done_cyc", 64'(done_cycle),   64'(a2 + 7));
    check_output("t1_ovf",      64'(load_ovf),     64'(1'b0));
    check_output("t1_core",     64'(core_rst_n),   64'(1'b1));
`ifdef BOOT_CHECKSUM_EN
    check_output("t1_chk_sum",  64'(chk_sum),      64'(8'h64));
`endif

    $display("[TB] partial last word, size 6");
    start_session(6, TGT_SRAM, 8'h65);
    apply_stimulus(32'h11223344, 9, a1);
    apply_stimulus(32'h55667788, 9, a2);
    check_output("t2_count", 64'(q_we.size()), 64'(6));
    check_log("t2_b4", 4, 1, 4, 8'h55, a2);
    check_log("t2_b5", 5, 1, 5, 8'h66, a2 + 2);
    check_output("t2_bytes",    64'(bytes_loaded), 64'(16'd6));
    check_output("t2_done",     64'(load_done),    64'(1'b1));
    check_output("t2_done_cyc", 64'(done_cycle),   64'(a2 + 3));
    check_output("t2_core",     64'(core_rst_n),   64'(1'b1));

    $display("[TB] word after done");
    clear_log();
    apply_stimulus(32'hDEADBEEF, 9, a3);
    check_output("t3_count",   64'(q_we.size()), 64'(0));
    check_output("t3_ovf",     64'(load_ovf),    64'(1'b1));
    check_output("t3_ovf_cyc", 64'(ovf_cycle),   64'(a3 + 1));
    check_output("t3_bytes",   64'(bytes_loaded), 64'(16'd6));
    check_output("t3_core",    64'(core_rst_n),  64'(1'b1));

    $display("[TB] boot_reset mid-word");
    start_session(8, TGT_SRAM, 8'h00);
    host_bus.host_data = 32'hA1B2C3D4;
    host_bus.host_req  = 1'b1;
    for (int i = 0; i < 5 && !host_bus.host_ack; i++) tick();
    tick();
    tick();
    check_output("t4_b1_we",   64'(mem_we),   64'(2'b01));
    check_output("t4_b1_data", 64'(mem_data), 64'(8'hB2));
    check_output("t4_b1_addr", 64'(mem_addr), 64'(19'd1));
    boot_reset = 1'b1;
    tick();
    check_output("t4_we",    64'(mem_we),            64'(2'b00));
    check_output("t4_bytes", 64'(bytes_loaded),      64'(16'd0));
    check_output("t4_done",  64'(load_done),         64'(1'b0));
    check_output("t4_ack",   64'(host_bus.host_ack), 64'(1'b0));
    boot_reset        = 1'b0;
    host_bus.host_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_output("t4_count", 64'(q_we.size()),  64'(2));
    check_output("t4_bytes_after", 64'(bytes_loaded), 64'(16'd0));

    $display("[TB] char target, size 4, long request hold");
    start_session(4, TGT_CHAR, 8'hC5);
    apply_stimulus(32'hCAFEF00D, 12, a5);
    check_output("t5_count", 64'(q_we.size()), 64'(4));
    for (int k = 0; k < 4; k++) begin
      check_log($sformatf("t5_b%0d", k), k, 1 << TGT_CHAR, k, int'(bytes_t5[k]), a5 + 2 * k);
    end
    check_output("t5_sram_pulses", 64'(sram_pulses), 64'(0));
    check_output("t5_done",        64'(load_done),   64'(1'b1));
    check_output("t5_core",        64'(core_rst_n),  64'(1'b1));
    reset = 1'b1;
    #1;
    check_output("t5_core_in_reset", 64'(core_rst_n), 64'(1'b0));
    tick();
    check_output("t5_rst_done", 64'(load_done),         64'(1'b0));
    check_output("t5_rst_ack",  64'(host_bus.host_ack), 64'(1'b0));
    reset = 1'b0;
    tick();

    $display("[TB] zero-byte session");
    start_session(0, TGT_SRAM, 8'h00);
    apply_stimulus(32'h12345678, 9, a6);
    check_output("t6_count",    64'(q_we.size()),  64'(0));
    check_output("t6_done",     64'(load_done),    64'(1'b1));
    check_output("t6_done_cyc", 64'(done_cycle),   64'(a6 + 1));
    check_output("t6_bytes",    64'(bytes_loaded), 64'(16'd0));
    check_output("t6_ovf",      64'(load_ovf),     64'(1'b0));
    check_output("t6_core",     64'(core_rst_n),   64'(1'b1));

`ifdef BOOT_CHECKSUM_EN
    $display("[TB] checksum match and mismatch");
    start_session(4, TGT_SRAM, 8'h0A);
    apply_stimulus(32'h01020304, 9, a1);
    check_output("t7_sum",  64'(chk_sum),    64'(8'h0A));
    check_output("t7_ok",   64'(chk_ok),     64'(1'b1));
    check_output("t7_core", 64'(core_rst_n), 64'(1'b1));
    start_session(4, TGT_SRAM, 8'h0B);
    apply_stimulus(32'h01020304, 9, a1);
    check_output("t8_sum",  64'(chk_sum),    64'(8'h0A));
    check_output("t8_done", 64'(load_done),  64'(1'b1));
    check_output("t8_ok",   64'(chk_ok),     64'(1'b0));
    check_output("t8_core", 64'(core_rst_n), 64'(1'b0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
